// File: rtl/debug_memory_dumper_if.sv
// rtl/debug_memory_dumper_if.sv - byte stream handshake between the memory dumper and the serial TX path
interface debug_memory_dumper_if #(
    parameter int BYTE_SIZE = 8
);
    logic [BYTE_SIZE-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/debug_memory_dumper.sv
// rtl/debug_memory_dumper.sv - snapshots the data-memory debug bus and streams it out byte by byte; DEBUG_DUMP_CHECKSUM_EN appends an XOR checksum byte
module debug_memory_dumper #(
    parameter int ADDR_SIZE = 5,
    parameter int SLOT_SIZE = 32,
    parameter int BYTE_SIZE = 8
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset,
    input  logic                                   i_start,
    input  logic [(2**ADDR_SIZE)*SLOT_SIZE-1:0]    i_bus_debug,
    debug_memory_dumper_if.master                  tx,
    output logic                                   o_busy,
    output logic                                   o_done
);
    localparam int NSLOTS     = 2**ADDR_SIZE;
    localparam int BPS        = SLOT_SIZE / BYTE_SIZE;
    localparam int NBYTES     = NSLOTS * BPS;
    localparam int TOTAL_BITS = NSLOTS * SLOT_SIZE;
    localparam int CW         = $clog2(NBYTES) + 1;
    localparam int IW         = $clog2(NBYTES);
`ifdef DEBUG_DUMP_CHECKSUM_EN
    // The checksum occupies one extra index past the last data byte.
    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES);
`else
    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);
`endif

    typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;

    state_t                state_q, state_d;
    logic [TOTAL_BITS-1:0] snapshot_q;
    logic [CW-1:0]         cnt_q;
    logic [BYTE_SIZE-1:0]  byte_arr [NBYTES];
    logic [BYTE_SIZE-1:0]  cur_byte;
    logic                  xfer;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [BYTE_SIZE-1:0]  csum_q;
`endif

    // Reorder the snapshot into transmit order: ascending slot, MSB lane first.
    for (genvar s = 0; s < NSLOTS; s++) begin : g_slot
        for (genvar l = 0; l < BPS; l++) begin : g_lane
            assign byte_arr[s*BPS + (BPS-1-l)] = snapshot_q[s*SLOT_SIZE + l*BYTE_SIZE +: BYTE_SIZE];
        end
    end

    assign xfer = tx.tx_valid && tx.tx_ready;

    // Select the byte currently offered downstream.
    always_comb begin
        cur_byte = byte_arr[cnt_q[IW-1:0]];
`ifdef DEBUG_DUMP_CHECKSUM_EN
        if (cnt_q == CW'(NBYTES)) begin
            cur_byte = csum_q;
        end
`endif
    end

    // State register; reset drops every status output without waiting for a clock.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start only from IDLE, leave SEND once the last byte is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = SEND;
            SEND:    if (xfer && (cnt_q == LAST_IDX)) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the bus on start and advance the byte pointer on each accepted transfer.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            snapshot_q <= '0;
            cnt_q      <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            if (state_q == IDLE && i_start) begin
                snapshot_q <= i_bus_debug;
                cnt_q      <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                csum_q     <= '0;
`endif
            end else if (state_q == SEND && xfer) begin
                cnt_q  <= cnt_q + 1'b1;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                csum_q <= csum_q ^ cur_byte;
`endif
            end
        end
    end

    // Outputs decode directly from state so they follow the async reset immediately.
    always_comb begin
        tx.tx_valid = (state_q == SEND);
        tx.tx_data  = cur_byte;
        o_busy      = (state_q != IDLE);
        o_done      = (state_q == FINISH);
    end
endmodule
